// File: rtl/bsg_dff_pipe_pkg.sv
// Shared definitions for the bsg_dff_reset_en_pipe register pipeline:
// occupancy counter width helper and the default reset value.
package bsg_dff_pipe_pkg;

  localparam int reset_val_default_lp = 0;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bsg_dff_pipe_stage.sv
// One valid+data stage of the elastic pipeline. The valid bit follows the
// upstream valid when advancing; data only loads when a real item arrives.
module bsg_dff_pipe_stage #(
  parameter int width_p = 8,
  parameter logic [width_p-1:0] reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               adv_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_o    <= 1'b0;
      data_o <= reset_val_p;
    end else if (flush_i) begin
      v_o <= 1'b0;
    end else if (adv_i) begin
      v_o <= v_i;
      if (v_i) data_o <= data_i;
    end
  end

endmodule

// File: rtl/bsg_dff_reset_en_pipe.sv
// depth_p-stage elastic register pipeline with bubble collapsing, async reset
// and synchronous flush. Define BSG_DFF_RESET_EN_PIPE_OCCUPANCY_EN to add count_o.
module bsg_dff_reset_en_pipe
  import bsg_dff_pipe_pkg::*;
#(
  parameter int width_p = 8,
  parameter int depth_p = 2,
  parameter logic [width_p-1:0] reset_val_p = width_p'(reset_val_default_lp)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
`ifdef BSG_DFF_RESET_EN_PIPE_OCCUPANCY_EN
  output logic [count_width(depth_p)-1:0] count_o,
`endif
  input  logic               yumi_i
);

  logic [depth_p-1:0] adv;
  logic [depth_p-1:0] v_r;
  logic [width_p-1:0] data_r [depth_p];
  logic               accept;

  // A stage may advance when it is empty or everything downstream moves.
  always_comb begin
    adv = '0;
    adv[depth_p-1] = ~v_r[depth_p-1] | yumi_i;
    for (int k = depth_p - 2; k >= 0; k--) begin
      adv[k] = ~v_r[k] | adv[k+1];
    end
  end

  assign ready_o = adv[0] & ~flush_i;
  assign accept  = v_i & ready_o;
  assign v_o     = v_r[depth_p-1];
  assign data_o  = data_r[depth_p-1];

  for (genvar k = 0; k < depth_p; k++) begin : g_stage
    logic               v_in;
    logic [width_p-1:0] d_in;
    if (k == 0) begin : g_head
      assign v_in = accept;
      assign d_in = data_i;
    end else begin : g_body
      assign v_in = v_r[k-1];
      assign d_in = data_r[k-1];
    end
    bsg_dff_pipe_stage #(
      .width_p    (width_p),
      .reset_val_p(reset_val_p)
    ) u_stage (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .flush_i(flush_i),
      .adv_i  (adv[k]),
      .v_i    (v_in),
      .data_i (d_in),
      .v_o    (v_r[k]),
      .data_o (data_r[k])
    );
  end

`ifdef BSG_DFF_RESET_EN_PIPE_OCCUPANCY_EN
  localparam int cw_lp = count_width(depth_p);
  logic deq;
  assign deq = yumi_i & v_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (flush_i) begin
      count_o <= '0;
    end else if (accept & ~deq) begin
      count_o <= count_o + cw_lp'(1);
    end else if (deq & ~accept) begin
      count_o <= count_o - cw_lp'(1);
    end
  end

`ifndef SYNTHESIS
  always @(negedge clk_i) begin
    if (!reset_i) assert (cw_lp'($countones(v_r)) == count_o);
  end
`endif
`endif

`ifndef SYNTHESIS
  // The consumer may only take data that is actually presented.
  always @(negedge clk_i) begin
    if (!reset_i) assert (!(yumi_i && !v_o));
  end
`endif

endmodule

// File: tb/tb_bsg_dff_reset_en_pipe.sv
// Self-checking bench for bsg_dff_reset_en_pipe (width 3, depth 3, reset 3'b101).
module tb_bsg_dff_reset_en_pipe;

  localparam int W = 3;
  localparam int D = 3;
  localparam logic [W-1:0] RST = 3'b101;

  logic         clk;
  logic         reset_i;
  logic         flush_i;
  logic         v_i;
  logic [W-1:0] data_i;
  logic         ready_o;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         yumi_i;
`ifdef BSG_DFF_RESET_EN_PIPE_OCCUPANCY_EN
  logic [1:0]   count_o;
`endif

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  bsg_dff_reset_en_pipe #(
    .width_p    (W),
    .depth_p    (D),
    .reset_val_p(RST)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .flush_i(flush_i),
    .v_i    (v_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .v_o    (v_o),
    .data_o (data_o),
`ifdef BSG_DFF_RESET_EN_PIPE_OCCUPANCY_EN
    .count_o(count_o),
`endif
    .yumi_i (yumi_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic yw, input logic f);
    v_i     = v;
    data_i  = d;
    yumi_i  = yw & v_o;
    flush_i = f;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !v_o) break;
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // scoreboard: reference model is an ordered FIFO of accepted items of capacity D
  always @(negedge clk) begin
    if (reset_i) begin
      exp_q.delete();
      chk("rst_v_o", v_o, 0);
      chk("rst_data_o", data_o, RST);
    end else begin
      chk("ready_o", ready_o, ((exp_q.size() < D) || yumi_i) && !flush_i);
      if (exp_q.size() == 0) chk("v_o_empty", v_o, 0);
      if (exp_q.size() == D) chk("v_o_full", v_o, 1);
`ifdef BSG_DFF_RESET_EN_PIPE_OCCUPANCY_EN
      chk("count_o", count_o, exp_q.size());
      chk("count_range", count_o <= D, 1);
`endif
      if (flush_i) begin
        exp_q.delete();
      end else begin
        if (yumi_i && v_o) begin
          if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
          else chk("data_order", data_o, exp_q.pop_front());
        end
        if (v_i && ready_o) exp_q.push_back(data_i);
      end
    end
  end

  logic [W-1:0] therm [4];

  initial begin
    therm[0] = 3'b000; therm[1] = 3'b001; therm[2] = 3'b011; therm[3] = 3'b111;
    reset_i = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    step(); step();
    reset_i = 1'b0;
    #1 chk("ready_after_reset", ready_o, 1);

    // 1: asynchronous reset while full
    drive(1'b1, 3'd6, 1'b0, 1'b0); step();
    drive(1'b1, 3'd2, 1'b0, 1'b0); step();
    drive(1'b1, 3'd4, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 chk("full_v_o", v_o, 1);
    #1 reset_i = 1'b1;
    #1 chk("async_rst_v_o", v_o, 0);
    chk("async_rst_data", data_o, RST);
    step();
    reset_i = 1'b0;
    #1 chk("ready_after_async_rst", ready_o, 1);

    // 2: thermometer stream, latency depth-1 edges, 1 item/cycle
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b1, therm[i], 1'b1, 1'b0);
      else drive(1'b0, '0, 1'b1, 1'b0);
      step();
      chk("therm_v_o", v_o, (i >= 2 && i <= 5));
      if (i >= 2 && i <= 5) chk("therm_data", data_o, therm[i-2]);
    end
    drain();

    // 3: fill, then pass-through ready when full
    drive(1'b1, 3'd1, 1'b0, 1'b0); step();
    drive(1'b1, 3'd3, 1'b0, 1'b0); step();
    drive(1'b1, 3'd7, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 chk("fill_ready", ready_o, 0);
    chk("fill_v_o", v_o, 1);
    chk("fill_data", data_o, 1);
    drive(1'b1, 3'd0, 1'b1, 1'b0);
    #1 chk("passthru_ready", ready_o, 1);
    step();
    drain();

    // 4: bubble collapse
    drive(1'b1, 3'd1, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0); step();
    drive(1'b1, 3'd3, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0); step(); step();
    chk("bubble_v_o", v_o, 1);
    chk("bubble_data", data_o, 1);
    chk("bubble_ready", ready_o, 1);
    drive(1'b1, 3'd5, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0);
    #1 chk("bubble_full_ready", ready_o, 0);
    drain();

    // 5: flush beats a simultaneous input
    drive(1'b1, 3'd2, 1'b0, 1'b0); step();
    drive(1'b1, 3'd6, 1'b0, 1'b0); step();
    drive(1'b0, '0, 1'b0, 1'b0); step(); step();
    drive(1'b1, 3'd7, 1'b0, 1'b1);
    #1 chk("flush_ready", ready_o, 0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("flush_v_o", v_o, 0);
`ifdef BSG_DFF_RESET_EN_PIPE_OCCUPANCY_EN
    chk("flush_count", count_o, 0);
`endif
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    drain();

    // 6: random valid/yumi mix
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
      step();
    end
    drain();

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
